// File: rtl/calculator_param.sv
// calculator_param: debounced four-switch hex calculator, ADD/SUB with borrow, result chaining; MUL when CALC_MULTIPLY_EN is defined
module calculator_param #(
  parameter int c_WIDTH          = 8,
  parameter int c_DEBOUNCE_LIMIT = 250000
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_Switch_1,
  input  logic               i_Switch_2,
  input  logic               i_Switch_3,
  input  logic               i_Switch_4,
  output logic [c_WIDTH-1:0] o_Result,
  output logic               o_Valid,
  output logic               o_Overflow,
  output logic [1:0]         o_Op,
  output logic [6:0]         o_Segment1,
  output logic [6:0]         o_Segment2
);
  localparam int DW = $clog2(c_DEBOUNCE_LIMIT + 1);
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
`ifdef CALC_MULTIPLY_EN
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam int MW = $clog2(c_WIDTH + 1);
`endif
  typedef enum logic [1:0] {ENTRY, COMPUTE, RESULT} state_t;
  logic [3:0] raw, filt, filt_q, press;
  state_t state, state_n;
  logic [c_WIDTH-1:0] a, a_n, b, b_n, res, res_n, shown;
  logic [1:0] op, op_n, op_next;
  logic last_b, last_b_n, ovf, ovf_n;
  logic [c_WIDTH:0] sum;
  logic [7:0] disp;
`ifdef CALC_MULTIPLY_EN
  logic [2*c_WIDTH-1:0] mcand, mcand_n, prod, prod_n;
  logic [c_WIDTH-1:0] mplier, mplier_n;
  logic [MW-1:0] mcnt, mcnt_n;
`endif
  assign raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};
  for (genvar i = 0; i < 4; i++) begin : g_db
    logic [DW-1:0] cnt;
    logic f;
    always_ff @(posedge i_Clk)
      if (i_Rst) begin
        cnt <= '0;
        f   <= 1'b0;
      end else if (raw[i] == f) cnt <= '0;
      else if (cnt == DW'(c_DEBOUNCE_LIMIT - 1)) begin
        cnt <= '0;
        f   <= raw[i];
      end else cnt <= cnt + DW'(1);
    assign filt[i] = f;
  end
  always_ff @(posedge i_Clk) filt_q <= i_Rst ? 4'b0 : filt;
  assign press = filt & ~filt_q;
  assign sum = {1'b0, a} + {1'b0, b};
`ifdef CALC_MULTIPLY_EN
  assign op_next = op == OP_ADD ? OP_SUB : (op == OP_SUB ? OP_MUL : OP_ADD);
`else
  assign op_next = op == OP_ADD ? OP_SUB : OP_ADD;
`endif
  always_ff @(posedge i_Clk)
    if (i_Rst) begin
      state  <= ENTRY;
      a      <= '0;
      b      <= '0;
      op     <= OP_ADD;
      last_b <= 1'b0;
      res    <= '0;
      ovf    <= 1'b0;
`ifdef CALC_MULTIPLY_EN
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      mcnt   <= '0;
`endif
    end else begin
      state  <= state_n;
      a      <= a_n;
      b      <= b_n;
      op     <= op_n;
      last_b <= last_b_n;
      res    <= res_n;
      ovf    <= ovf_n;
`ifdef CALC_MULTIPLY_EN
      mcand  <= mcand_n;
      mplier <= mplier_n;
      prod   <= prod_n;
      mcnt   <= mcnt_n;
`endif
    end
  always_comb begin
    state_n  = state;
    a_n      = a;
    b_n      = b;
    op_n     = op;
    last_b_n = last_b;
    res_n    = res;
    ovf_n    = ovf;
`ifdef CALC_MULTIPLY_EN
    mcand_n  = {{c_WIDTH{1'b0}}, a};
    mplier_n = b;
    prod_n   = '0;
    mcnt_n   = '0;
`endif
    case (state)
      ENTRY:
        if (press[3]) state_n = COMPUTE;
        else if (press[2]) op_n = op_next;
        else begin
          if (press[0]) begin
            a_n      = a + c_WIDTH'(1);
            last_b_n = 1'b0;
          end
          if (press[1]) begin
            b_n      = b + c_WIDTH'(1);
            last_b_n = 1'b1;
          end
        end
      COMPUTE:
        if (op == OP_SUB) begin
          res_n   = a - b;
          ovf_n   = a < b;
          state_n = RESULT;
        end
`ifdef CALC_MULTIPLY_EN
        else if (op == OP_MUL) begin
          mcand_n  = mcand << 1;
          mplier_n = mplier >> 1;
          prod_n   = prod + (mplier[0] ? mcand : '0);
          mcnt_n   = mcnt + MW'(1);
          if (mcnt == MW'(c_WIDTH)) begin
            res_n   = prod[c_WIDTH-1:0];
            ovf_n   = |prod[2*c_WIDTH-1:c_WIDTH];
            state_n = RESULT;
          end
        end
`endif
        else begin
          {ovf_n, res_n} = sum;
          state_n        = RESULT;
        end
      RESULT:
        if (press[3]) begin
          a_n      = res;
          b_n      = '0;
          last_b_n = 1'b0;
          state_n  = ENTRY;
        end else if (|press[1:0]) begin
          a_n     = '0;
          b_n     = '0;
          state_n = ENTRY;
        end
      default: state_n = ENTRY;
    endcase
  end
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b0000001;
      4'h1: seg7 = 7'b1001111;
      4'h2: seg7 = 7'b0010010;
      4'h3: seg7 = 7'b0000110;
      4'h4: seg7 = 7'b1001100;
      4'h5: seg7 = 7'b0100100;
      4'h6: seg7 = 7'b0100000;
      4'h7: seg7 = 7'b0001111;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0000100;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b1100000;
      4'hC: seg7 = 7'b0110001;
      4'hD: seg7 = 7'b1000010;
      4'hE: seg7 = 7'b0110000;
      default: seg7 = 7'b0111000;
    endcase
  endfunction
  assign shown      = state == RESULT ? res : (last_b ? b : a);
  assign disp       = 8'(shown);
  assign o_Segment1 = seg7(disp[7:4]);
  assign o_Segment2 = seg7(disp[3:0]);
  assign o_Result   = res;
  assign o_Overflow = ovf;
  assign o_Valid    = state == RESULT;
  assign o_Op       = op;
endmodule

// File: tb/tb_calculator_param.sv
// tb_calculator_param: random switch presses against a behavioural calculator model, plus directed corner cases
module tb_calculator_param;
  localparam int W = 8, L = 50, HOLD = 200;
`ifdef CALC_MULTIPLY_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] sw = '0;
  logic [W-1:0] result;
  logic valid, ovf;
  logic [1:0] op;
  logic [6:0] seg1, seg2;
  int checks = 0, errors = 0;
  int ma, mb, mop, mres;
  bit mlast_b, movf, mvalid;
  logic [6:0] seg_hi [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                              7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
  calculator_param #(.c_WIDTH(W), .c_DEBOUNCE_LIMIT(L)) dut (
    .i_Clk(clk), .i_Rst(rst),
    .i_Switch_1(sw[0]), .i_Switch_2(sw[1]), .i_Switch_3(sw[2]), .i_Switch_4(sw[3]),
    .o_Result(result), .o_Valid(valid), .o_Overflow(ovf), .o_Op(op),
    .o_Segment1(seg1), .o_Segment2(seg2)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_all(input string tag);
    int shown;
    logic [3:0] hi, lo;
    logic [6:0] e1, e2;
    shown = mvalid ? mres : (mlast_b ? mb : ma);
    hi = 4'(shown >> 4);
    lo = 4'(shown);
    e1 = ~seg_hi[hi];
    e2 = ~seg_hi[lo];
    check({tag, ".result"}, result, mres);
    check({tag, ".overflow"}, ovf, movf);
    check({tag, ".valid"}, valid, mvalid);
    check({tag, ".op"}, op, mop);
    check({tag, ".seg1"}, seg1, e1);
    check({tag, ".seg2"}, seg2, e2);
  endtask
  task automatic model_press(input int n, output int lat);
    int x;
    lat = -1;
    if (!mvalid) begin
      if (n == 4) begin
        x = mop == 0 ? ma + mb : (mop == 1 ? ma - mb : ma * mb);
        mres = x & 'hFF;
        movf = mop == 1 ? ma < mb : x > 255;
        mvalid = 1'b1;
        lat = L + 2 + (mop == 2 ? W : 0);
      end else if (n == 3) mop = mop == 0 ? 1 : ((mop == 1 && MUL_EN) ? 2 : 0);
      else if (n == 1) begin
        ma = (ma + 1) % 256;
        mlast_b = 1'b0;
      end else begin
        mb = (mb + 1) % 256;
        mlast_b = 1'b1;
      end
    end else if (n == 4) begin
      ma = mres;
      mb = 0;
      mlast_b = 1'b0;
      mvalid = 1'b0;
    end else if (n != 3) begin
      ma = 0;
      mb = 0;
      mvalid = 1'b0;
    end
  endtask
  task automatic press(input int n, input string tag);
    int exp_lat, lat;
    bit was;
    model_press(n, exp_lat);
    was = valid;
    lat = -1;
    sw[n-1] = 1'b1;
    for (int k = 1; k <= HOLD; k++) begin
      @(posedge clk);
      #1;
      if (lat < 0 && valid && !was) lat = k;
    end
    sw[n-1] = 1'b0;
    repeat (HOLD) @(posedge clk);
    #1;
    if (exp_lat >= 0) check({tag, ".latency"}, lat, exp_lat);
    check_all(tag);
  endtask
  task automatic presses(input int n, input int times, input string tag);
    for (int k = 0; k < times; k++) press(n, tag);
  endtask
  task automatic model_reset();
    ma = 0; mb = 0; mop = 0; mres = 0; movf = 1'b0; mvalid = 1'b0; mlast_b = 1'b0;
  endtask
  task automatic do_reset(input string tag);
    @(posedge clk);
    #1;
    rst = 1'b1;
    sw = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check_all(tag);
  endtask
  initial begin
    model_reset();
    do_reset("reset");
    presses(1, 2, "add_a");
    presses(2, 3, "add_b");
    press(4, "add");
    check("add.result_lit", result, 5);
    check("add.seg2_lit", seg2, 7'b0100100);
    check("add.seg1_lit", seg1, 7'b0000001);
    press(4, "chain");
    presses(2, 2, "chain_b");
    press(4, "chain_eq");
    check("chain.result_lit", result, 7);
    do_reset("reset2");
    presses(1, 2, "sub_a");
    presses(2, 3, "sub_b");
    press(3, "sub_op");
    check("sub.op_lit", op, 2'b01);
    press(4, "sub");
    check("sub.result_lit", result, 8'hFF);
    check("sub.overflow_lit", ovf, 1);
    check("sub.seg1_lit", seg1, 7'b0111000);
    check("sub.seg2_lit", seg2, 7'b0111000);
    press(3, "result_sw3");
    press(1, "result_clear");
    press(1, "pre_glitch");
    sw[0] = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    sw[0] = 1'b0;
    repeat (HOLD) @(posedge clk);
    #1;
    check_all("glitch");
`ifdef CALC_MULTIPLY_EN
    do_reset("reset_mul");
    presses(1, 3, "mul_a");
    presses(2, 5, "mul_b");
    presses(3, 2, "mul_op");
    check("mul.op_lit", op, 2'b10);
    press(4, "mul");
    check("mul.result_lit", result, 15);
    do_reset("reset_mul16");
    presses(1, 16, "mul16_a");
    presses(2, 16, "mul16_b");
    presses(3, 2, "mul16_op");
    press(4, "mul16");
    check("mul16.result_lit", result, 0);
    check("mul16.overflow_lit", ovf, 1);
    do_reset("reset_mid");
    presses(1, 3, "mid_a");
    presses(2, 5, "mid_b");
    presses(3, 2, "mid_op");
    sw[3] = 1'b1;
    repeat (L + 4) @(posedge clk);
    #1;
    check("mid.busy", valid, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sw = '0;
    model_reset();
    check_all("mid_reset");
    check("mid.seg1_lit", seg1, 7'b0000001);
    repeat (HOLD) @(posedge clk);
    #1;
    check_all("mid_settle");
`endif
    do_reset("reset_rnd");
    for (int i = 0; i < 50; i++) press(int'($urandom_range(1, 4)), $sformatf("rnd%0d", i));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
